piece_collide_scan: RTL and testbench
=====================================

# piece_collide_scan

Sequential collision checker for the tetris playfield. On `start` it captures a piece bitmap, rotation and signed position, then walks the PIECE_N×PIECE_N piece grid one cell per clock, testing each occupied cell against the field walls, the floor and the occupancy bitmap. It reports `collide` plus a cause code with a one-cycle `done` pulse. It sits between the game-control FSM (move/rotate/drop requests) and the field register, and replaces the per-cell combinational check.

## Interface
- FIELD_W, 20, field width in cells (x)
- FIELD_H, 20, field height in cells (y)
- PIECE_N, 4, piece grid edge length
- POS_W, 6, width of signed position inputs
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; accepted only when `ready`=1
- ready  out  1  can accept `start`
- piece  in  PIECE_N*PIECE_N  bitmap; bit r*PIECE_N+c = row r, col c
- rotate  in  2  0/90/180/270 degrees clockwise
- pos_x  in  POS_W  signed x of piece col 0
- pos_y  in  POS_W  signed y of piece row 0
- field  in  FIELD_W*FIELD_H  occupancy; bit y*FIELD_W+x
- done  out  1  one-cycle pulse, result valid
- collide  out  1  collision found
- cause  out  2  0 NONE, 1 WALL, 2 FLOOR, 3 OVERLAP

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state IDLE.
- `ready`=1 in IDLE and DONE.
- On an accepted `start`, `piece`, `rotate`, `pos_x` and `pos_y` are registered. `collide` and `cause` clear to 0, the cell index `idx` is set to 0, and the FSM enters SCAN.
- `field` is not captured. The requester holds it stable while `ready`=0.
- `start` while `ready`=0 is ignored.
- Rotated cell (r,c), with r=idx/PIECE_N and c=idx%PIECE_N, takes its value from source bit:
  - rot0: (r,c)
  - rot1: (N-1-c, r)
  - rot2: (N-1-r, N-1-c)
  - rot3: (c, N-1-r)
- Cell coordinates: x=pos_x+c, y=pos_y+r. Both are computed signed at POS_W+1 bits, so no overflow.
- An occupied cell is tested in priority order:
  - x<0 or x≥FIELD_W: WALL
  - else y≥FIELD_H: FLOOR
  - else y≥0 and field bit set: OVERLAP
- y<0 is legal (spawn area above the field) unless the cell is a WALL case.
- Only the first collision found is recorded. Later hits never overwrite `cause`.
- After idx=N*N-1 is evaluated, or earlier per Configuration, the FSM enters DONE. `done`=1 for exactly that cycle, then the FSM returns to IDLE.
- A `start` accepted in DONE goes straight to SCAN (back-to-back checks).
- `collide` and `cause` hold until the next accepted `start`.
- An all-zero piece scans fully and gives collide=0, cause NONE.

## Timing
- Reset (at any time, including mid-SCAN): state IDLE, ready=1, done=0, collide=0, cause=0, idx=0.
- Accept edge is t0. Cell i is evaluated in the cycle after edge t0+i, and its result is registered at edge t0+i+1.
- Full scan: `done` is high between edges t0+N*N and t0+N*N+1 (16 cycles of latency for N=4).
- Throughput: one check per N*N+1 cycles when fully scanning.

## Configuration
- COLLIDE_EARLY_EXIT_EN defined: the FSM leaves SCAN on the edge that registers the first collision. For a first hit at cell k, `done` is high after edge t0+k+1.
- COLLIDE_EARLY_EXIT_EN undefined: every check scans all N*N cells and latency is fixed. Result values are identical either way.

## Structure
- Shared package `tetris_pkg`:
  - cause enum (NONE/WALL/FLOOR/OVERLAP)
  - FSM state enum
  - rotation constants
  - default FIELD_W/FIELD_H
- Sub-module `piece_rotate_index`: combinational mapping of (rotate, r, c) to the source bit index, reused by the renderer.

## Test plan
- Empty field; piece 16'h0033, rot0, pos (5,5) -> collide=0, cause 0, `done` 16 cycles after accept.
- Empty field; 16'h0033, pos (19,5) -> WALL found at cell 1. Early exit: `done` after 2 cycles. Without early exit: 16 cycles, same result.
- Empty field; 16'h0033, pos (5,19) -> FLOOR at cell 4.
- Field bit 126 set (x=6, y=6); 16'h0033, pos (5,5) -> OVERLAP at cell 5. Same setup at pos (5,-2) -> no collision (y<0 allowed; no occupied cell reaches y=6).
- I piece 16'h000F, pos (-3,0): rot0 -> WALL; rot1 (vertical, column x=0) -> no collision.
- Assert rst at SCAN cell 7 -> all outputs 0, ready=1 immediately. `start` pulses during SCAN are ignored. `start` during DONE is accepted and the new result is correct.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris playfield logic.
//
// Contents:
//   cause_t        collision cause code (NONE / WALL / FLOOR / OVERLAP)
//   scan_state_t   state encoding of the sequential collision scanner
//   ROT_*          rotation selector values (clockwise quarter turns)
//   FIELD_W_DEF    default playfield width in cells
//   FIELD_H_DEF    default playfield height in cells
package tetris_pkg;

    localparam int FIELD_W_DEF = 20;
    localparam int FIELD_H_DEF = 20;

    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_WALL    = 2'd1,
        CAUSE_FLOOR   = 2'd2,
        CAUSE_OVERLAP = 2'd3
    } cause_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/piece_rotate_index.sv
// Combinational rotation lookup: for a cell (row, col) of the rotated piece
// grid, returns the bit index in the unrotated piece bitmap that supplies
// its value. Shared by the collision scanner and the renderer.
//
// Parameters:
//   PIECE_N   piece grid edge length
// Ports:
//   rotate    in   2            clockwise quarter turns (0..3)
//   row       in   RC_W         rotated-grid row
//   col       in   RC_W         rotated-grid column
//   src_idx   out  IDX_W        source bit index (src_row*PIECE_N + src_col)
module piece_rotate_index
    import tetris_pkg::*;
#(
    parameter int PIECE_N = 4,
    parameter int RC_W    = (PIECE_N > 1) ? $clog2(PIECE_N) : 1,
    parameter int IDX_W   = (PIECE_N > 1) ? $clog2(PIECE_N * PIECE_N) : 1
) (
    input  logic [1:0]       rotate,
    input  logic [RC_W-1:0]  row,
    input  logic [RC_W-1:0]  col,
    output logic [IDX_W-1:0] src_idx
);

    localparam logic [RC_W-1:0] NM1 = RC_W'(PIECE_N - 1);

    logic [RC_W-1:0] src_row;
    logic [RC_W-1:0] src_col;

    always_comb begin
        src_row = row;
        src_col = col;
        case (rotate)
            ROT_90: begin
                src_row = NM1 - col;
                src_col = row;
            end
            ROT_180: begin
                src_row = NM1 - row;
                src_col = NM1 - col;
            end
            ROT_270: begin
                src_row = col;
                src_col = NM1 - row;
            end
            default: begin
                src_row = row;
                src_col = col;
            end
        endcase
    end

    assign src_idx = IDX_W'(src_row) * IDX_W'(PIECE_N) + IDX_W'(src_col);

endmodule

// File: rtl/piece_collide_scan.sv
// Sequential collision checker. On an accepted start it captures the piece
// bitmap, rotation and signed position, then tests one grid cell per clock
// against the side walls, the floor and the field occupancy. The first
// collision found is kept; done pulses for one cycle when the result is final.
//
// Optional feature: define COLLIDE_EARLY_EXIT_EN to end the scan on the edge
// that registers the first collision instead of always walking every cell.
//
// Ports:
//   clk      in   1                  clock
//   rst      in   1                  asynchronous active-high reset
//   start    in   1                  check request, taken when ready=1
//   ready    out  1                  high in IDLE and DONE
//   piece    in   PIECE_N*PIECE_N    bitmap, bit r*PIECE_N+c
//   rotate   in   2                  clockwise quarter turns
//   pos_x    in   POS_W              signed x of piece column 0
//   pos_y    in   POS_W              signed y of piece row 0
//   field    in   FIELD_W*FIELD_H    occupancy, bit y*FIELD_W+x (held while busy)
//   done     out  1                  one-cycle result-valid pulse
//   collide  out  1                  collision found
//   cause    out  2                  0 NONE, 1 WALL, 2 FLOOR, 3 OVERLAP
module piece_collide_scan
    import tetris_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int FIELD_H = FIELD_H_DEF,
    parameter int PIECE_N = 4,
    parameter int POS_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       ready,
    input  logic [PIECE_N*PIECE_N-1:0] piece,
    input  logic [1:0]                 rotate,
    input  logic [POS_W-1:0]           pos_x,
    input  logic [POS_W-1:0]           pos_y,
    input  logic [FIELD_W*FIELD_H-1:0] field,
    output logic                       done,
    output logic                       collide,
    output logic [1:0]                 cause
);

    localparam int RC_W  = (PIECE_N > 1) ? $clog2(PIECE_N) : 1;
    localparam int IDX_W = (PIECE_N > 1) ? $clog2(PIECE_N * PIECE_N) : 1;
    localparam int FI_W  = $clog2(FIELD_W * FIELD_H);
    localparam int CW    = POS_W + 1;

    scan_state_t               state;
    scan_state_t               state_next;
    logic [PIECE_N*PIECE_N-1:0] piece_q;
    logic [1:0]                rot_q;
    logic [POS_W-1:0]          px_q;
    logic [POS_W-1:0]          py_q;
    logic [IDX_W-1:0]          idx;
    logic                      collide_q;
    cause_t                    cause_q;

    logic                      accept;
    logic                      last_cell;
    logic                      early_stop;
    logic [RC_W-1:0]           cell_r;
    logic [RC_W-1:0]           cell_c;
    logic [IDX_W-1:0]          src_idx;
    logic                      cell_on;
    logic signed [CW-1:0]      x_s;
    logic signed [CW-1:0]      y_s;
    logic [CW-1:0]             x_u;
    logic [CW-1:0]             y_u;
    logic [FI_W-1:0]           fidx;
    cause_t                    hit_cause;
    logic                      cell_hit;

    assign ready     = (state != ST_SCAN);
    assign done      = (state == ST_DONE);
    assign collide   = collide_q;
    assign cause     = cause_q;
    assign accept    = start && ready;
    assign last_cell = (idx == IDX_W'(PIECE_N * PIECE_N - 1));

    assign cell_r = RC_W'(idx / IDX_W'(PIECE_N));
    assign cell_c = RC_W'(idx % IDX_W'(PIECE_N));

    piece_rotate_index #(
        .PIECE_N (PIECE_N)
    ) u_rot (
        .rotate  (rot_q),
        .row     (cell_r),
        .col     (cell_c),
        .src_idx (src_idx)
    );

    assign cell_on = piece_q[src_idx];

    // Positions are sign-extended one bit before adding the in-grid offset
    // so the cell coordinate can never wrap.
    assign x_s  = $signed({px_q[POS_W-1], px_q}) + $signed(CW'(cell_c));
    assign y_s  = $signed({py_q[POS_W-1], py_q}) + $signed(CW'(cell_r));
    assign x_u  = x_s;
    assign y_u  = y_s;
    assign fidx = FI_W'(y_u) * FI_W'(FIELD_W) + FI_W'(x_u);

    // Walls take priority over the floor, and the field is only consulted
    // once the cell is known to lie inside it; rows above the field are free.
    always_comb begin
        hit_cause = CAUSE_NONE;
        if (cell_on) begin
            if (x_s[CW-1] || (x_u >= CW'(FIELD_W))) begin
                hit_cause = CAUSE_WALL;
            end else if (!y_s[CW-1] && (y_u >= CW'(FIELD_H))) begin
                hit_cause = CAUSE_FLOOR;
            end else if (!y_s[CW-1] && field[fidx]) begin
                hit_cause = CAUSE_OVERLAP;
            end
        end
    end

    assign cell_hit = (hit_cause != CAUSE_NONE);

`ifdef COLLIDE_EARLY_EXIT_EN
    assign early_stop = cell_hit && !collide_q;
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE lasts one cycle; a start seen there chains straight into a new scan.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_SCAN;
            ST_SCAN: if (last_cell || early_stop) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_SCAN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Only the first hit of a scan is recorded; later hits leave the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            piece_q   <= '0;
            rot_q     <= ROT_0;
            px_q      <= '0;
            py_q      <= '0;
            idx       <= '0;
            collide_q <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else if (accept) begin
            piece_q   <= piece;
            rot_q     <= rotate;
            px_q      <= pos_x;
            py_q      <= pos_y;
            idx       <= '0;
            collide_q <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else if (state == ST_SCAN) begin
            idx <= idx + 1'b1;
            if (cell_hit && !collide_q) begin
                collide_q <= 1'b1;
                cause_q   <= hit_cause;
            end
        end
    end

endmodule

// File: tb/tb_piece_collide_scan.sv
// Scoreboard bench for piece_collide_scan. Each accepted request pushes its
// hand-computed result and latency; a monitor pops and compares on done.
// Honours COLLIDE_EARLY_EXIT_EN for the expected latency.
module tb_piece_collide_scan;

    localparam int FW = 20;
    localparam int FH = 20;
    localparam int N  = 4;
    localparam int PW = 6;

    typedef struct {
        logic       collide;
        logic [1:0] cause;
        int         lat;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             ready;
    logic [N*N-1:0]   piece;
    logic [1:0]       rotate;
    logic [PW-1:0]    pos_x;
    logic [PW-1:0]    pos_y;
    logic [FW*FH-1:0] field;
    logic             done;
    logic             collide;
    logic [1:0]       cause;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   cycle_cnt;
    int   acc_cycle;

    piece_collide_scan #(
        .FIELD_W (FW),
        .FIELD_H (FH),
        .PIECE_N (N),
        .POS_W   (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ready   (ready),
        .piece   (piece),
        .rotate  (rotate),
        .pos_x   (pos_x),
        .pos_y   (pos_y),
        .field   (field),
        .done    (done),
        .collide (collide),
        .cause   (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Expected cycles from the accept edge to the edge that raises done;
    // first_hit < 0 means no collision anywhere in the grid.
    function automatic int exp_lat(input int first_hit);
`ifdef COLLIDE_EARLY_EXIT_EN
        return (first_hit < 0) ? N * N : first_hit + 1;
`else
        return N * N;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drives one request. When sync is set the caller is already at a
    // negedge (e.g. the DONE cycle) and the request goes out immediately.
    task automatic applyStimulus(input logic [N*N-1:0] p, input logic [1:0] rot,
                                 input int px, input int py,
                                 input logic ecol, input logic [1:0] ecause,
                                 input int first_hit, input bit sync);
        exp_t e;
        if (!sync) @(negedge clk);
        piece  = p;
        rotate = rot;
        pos_x  = PW'(px);
        pos_y  = PW'(py);
        start  = 1'b1;
        e.collide = ecol;
        e.cause   = ecause;
        e.lat     = exp_lat(first_hit);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        acc_cycle = cycle_cnt;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, int'(seen), 1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("collide", int'(collide), int'(e.collide));
                checkOutput("cause", int'(cause), int'(e.cause));
                checkOutput("latency", cycle_cnt - acc_cycle, e.lat);
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cycle_cnt = 0;
        acc_cycle = 0;
        rst    = 1'b1;
        start  = 1'b0;
        piece  = '0;
        rotate = 2'd0;
        pos_x  = '0;
        pos_y  = '0;
        field  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("reset_ready", int'(ready), 1);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_collide", int'(collide), 0);
        checkOutput("reset_cause", int'(cause), 0);

        // Square in open space; also probe ready and a stray start mid-scan.
        applyStimulus(16'h0033, 2'd0, 5, 5, 1'b0, 2'd0, -1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("busy_ready", int'(ready), 0);
        piece = 16'h0033;
        pos_x = PW'(19);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("open");

        // Right wall at cell 1, floor at cell 4.
        applyStimulus(16'h0033, 2'd0, 19, 5, 1'b1, 2'd1, 1, 1'b0);
        wait_done("wall");
        applyStimulus(16'h0033, 2'd0, 5, 19, 1'b1, 2'd2, 4, 1'b0);
        wait_done("floor");

        // Occupied cell (6,6) = bit 126; above-field placement is harmless.
        field[126] = 1'b1;
        applyStimulus(16'h0033, 2'd0, 5, 5, 1'b1, 2'd3, 5, 1'b0);
        wait_done("overlap");
        applyStimulus(16'h0033, 2'd0, 5, -2, 1'b0, 2'd0, -1, 1'b0);
        wait_done("spawn");
        field = '0;

        // I piece: horizontal pokes through the left wall, vertical sits at x=0.
        applyStimulus(16'h000F, 2'd0, -3, 0, 1'b1, 2'd1, 0, 1'b0);
        wait_done("i_rot0");
        applyStimulus(16'h000F, 2'd1, -3, 0, 1'b0, 2'd0, -1, 1'b0);
        wait_done("i_rot1");
        // Rot2 of row 0 lands in row 3 cols 0..3: x=-3..0, first hit at cell 12.
        applyStimulus(16'h000F, 2'd2, -3, 0, 1'b1, 2'd1, 12, 1'b0);
        wait_done("i_rot2");

        // Empty piece far out of bounds still scans clean.
        applyStimulus(16'h0000, 2'd3, 30, 30, 1'b0, 2'd0, -1, 1'b0);
        wait_done("empty");

        // Back-to-back: second request issued in the DONE cycle.
        applyStimulus(16'h0033, 2'd0, 19, 5, 1'b1, 2'd1, 1, 1'b0);
        wait_done("b2b_first");
        applyStimulus(16'h0033, 2'd0, 5, 19, 1'b1, 2'd2, 4, 1'b1);
        wait_done("b2b_second");

        // Reset while scanning cell 7 must drop everything immediately.
        @(negedge clk);
        piece = 16'h0033;
        pos_x = PW'(5);
        pos_y = PW'(5);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset_ready", int'(ready), 1);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_collide", int'(collide), 0);
        checkOutput("midreset_cause", int'(cause), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_ready", int'(ready), 1);

        applyStimulus(16'h0033, 2'd0, 19, 5, 1'b1, 2'd1, 1, 1'b0);
        wait_done("after_reset");

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
